// File: rtl/symbol_pacer_fifo_if.sv
// Bus bundle for symbol_pacer_fifo: AHB-bridge push side, pacing control and DAC writer handshake.
// idle_symbol exists only when SYMBOL_PACER_IDLE_SYMBOL_EN is defined.
interface symbol_pacer_fifo_if #(
   parameter int SYM_W      = 6,
   parameter int DEPTH_LOG2 = 4,
   parameter int PER_W      = 16
);
   logic                  push;
   logic [SYM_W-1:0]      push_data;
   logic                  full;
   logic [DEPTH_LOG2:0]   level;
   logic                  enable;
   logic [PER_W-1:0]      sym_period;
   logic                  clr_underrun;
   logic                  underrun;
   logic [SYM_W-1:0]      symbol;
   logic                  dac_start;
   logic                  dac_ready;
`ifdef SYMBOL_PACER_IDLE_SYMBOL_EN
   logic [SYM_W-1:0]      idle_symbol;

   modport master (
      output push, push_data, enable, sym_period, clr_underrun, dac_ready, idle_symbol,
      input  full, level, underrun, symbol, dac_start
   );
   modport slave (
      input  push, push_data, enable, sym_period, clr_underrun, dac_ready, idle_symbol,
      output full, level, underrun, symbol, dac_start
   );
`else
   modport master (
      output push, push_data, enable, sym_period, clr_underrun, dac_ready,
      input  full, level, underrun, symbol, dac_start
   );
   modport slave (
      input  push, push_data, enable, sym_period, clr_underrun, dac_ready,
      output full, level, underrun, symbol, dac_start
   );
`endif
endinterface

// File: rtl/symbol_pacer_fifo.sv
// Symbol FIFO that releases one symbol per programmable period to the DAC writer (4-phase start/ready).
// Optional SYMBOL_PACER_IDLE_SYMBOL_EN: on underrun, write idle_symbol to the DAC instead of going silent.
//
// state   | meaning
// IDLE    | waiting for a period tick (or a pending one)
// ISSUE   | pop FIFO head into symbol, raise dac_start
// FILL    | load idle_symbol, raise dac_start (idle-symbol build only)
// START   | dac_start held until the writer drops ready
// BUSY    | waiting for the writer to return ready
module symbol_pacer_fifo #(
   parameter int SYM_W      = 6,
   parameter int DEPTH_LOG2 = 4,
   parameter int PER_W      = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   symbol_pacer_fifo_if.slave    bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LVL_W = DEPTH_LOG2 + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_FILL,
      S_START,
      S_BUSY
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [SYM_W-1:0]    r_mem [DEPTH];
   logic [LVL_W-1:0]    r_wr_ptr;
   logic [LVL_W-1:0]    r_rd_ptr;
   logic [PER_W-1:0]    r_per_cnt;
   logic                r_tick_pend;
   logic                r_underrun;
   logic [SYM_W-1:0]    r_symbol;
   logic                r_dac_start;

   logic [LVL_W-1:0]    w_level;
   logic                w_full;
   logic                w_push_ok;
   logic [PER_W-1:0]    w_reload;
   logic                w_tick;
   logic                w_fire;
   logic                w_pop;
   logic                w_load_head;
   logic                w_underrun_set;
   logic                w_pend_clr;
   logic                w_start_set;
   logic                w_start_clr;
`ifdef SYMBOL_PACER_IDLE_SYMBOL_EN
   logic                w_load_idle;
`endif

   assign w_level   = r_wr_ptr - r_rd_ptr;
   assign w_full    = (w_level == LVL_W'(DEPTH));
   assign w_push_ok = bus.push && !w_full;

   // Periods of 0 and 1 both reload to 0, i.e. a tick every cycle.
   assign w_reload = (bus.sym_period == '0) ? '0 : bus.sym_period - PER_W'(1);
   assign w_tick   = bus.enable && (r_per_cnt == '0);
   assign w_fire   = bus.enable && (w_tick || r_tick_pend);

   always_ff @(posedge HCLK) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= bus.push_data;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + LVL_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + LVL_W'(1);
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_per_cnt <= '0;
      end else if (!bus.enable || (r_per_cnt == '0)) begin
         r_per_cnt <= w_reload;
      end else begin
         r_per_cnt <= r_per_cnt - PER_W'(1);
      end
   end

   // A tick landing while a transfer is in flight must survive an ISSUE clear.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_tick_pend <= 1'b0;
      end else if (!bus.enable) begin
         r_tick_pend <= 1'b0;
      end else if (w_tick && (r_state != S_IDLE)) begin
         r_tick_pend <= 1'b1;
      end else if (w_pend_clr) begin
         r_tick_pend <= 1'b0;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next         = r_state;
      w_pop          = 1'b0;
      w_load_head    = 1'b0;
      w_underrun_set = 1'b0;
      w_pend_clr     = 1'b0;
      w_start_set    = 1'b0;
      w_start_clr    = 1'b0;
`ifdef SYMBOL_PACER_IDLE_SYMBOL_EN
      w_load_idle    = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_fire) begin
               if (w_level != '0) begin
                  w_next = S_ISSUE;
               end else begin
                  w_underrun_set = 1'b1;
                  w_pend_clr     = 1'b1;
`ifdef SYMBOL_PACER_IDLE_SYMBOL_EN
                  w_next         = S_FILL;
`endif
               end
            end
         end
         S_ISSUE: begin
            w_pop       = 1'b1;
            w_load_head = 1'b1;
            w_start_set = 1'b1;
            w_pend_clr  = 1'b1;
            w_next      = S_START;
         end
`ifdef SYMBOL_PACER_IDLE_SYMBOL_EN
         S_FILL: begin
            w_load_idle = 1'b1;
            w_start_set = 1'b1;
            w_next      = S_START;
         end
`endif
         S_START: begin
            if (!bus.dac_ready) begin
               w_start_clr = 1'b1;
               w_next      = S_BUSY;
            end
         end
         S_BUSY: begin
            if (bus.dac_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_symbol    <= '0;
         r_dac_start <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         if (w_load_head) begin
            r_symbol <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
         end
`ifdef SYMBOL_PACER_IDLE_SYMBOL_EN
         else if (w_load_idle) begin
            r_symbol <= bus.idle_symbol;
         end
`endif
         if (w_start_set) begin
            r_dac_start <= 1'b1;
         end else if (w_start_clr) begin
            r_dac_start <= 1'b0;
         end
         if (w_underrun_set) begin
            r_underrun <= 1'b1;
         end else if (bus.clr_underrun) begin
            r_underrun <= 1'b0;
         end
      end
   end

   assign bus.full      = w_full;
   assign bus.level     = w_level;
   assign bus.underrun  = r_underrun;
   assign bus.symbol    = r_symbol;
   assign bus.dac_start = r_dac_start;
endmodule

// File: tb/tb_symbol_pacer_fifo.sv
// Directed bench for symbol_pacer_fifo with a negedge DAC-writer model and start/symbol monitor.
module tb_symbol_pacer_fifo;
   localparam int SYM_W      = 6;
   localparam int DEPTH_LOG2 = 4;
   localparam int PER_W      = 16;

   logic HCLK    = 1'b0;
   logic HRESETn = 1'b0;

   symbol_pacer_fifo_if #(.SYM_W(SYM_W), .DEPTH_LOG2(DEPTH_LOG2), .PER_W(PER_W)) bus_if();

   symbol_pacer_fifo #(.SYM_W(SYM_W), .DEPTH_LOG2(DEPTH_LOG2), .PER_W(PER_W)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus_if.slave)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [SYM_W-1:0]    din;
      logic [DEPTH_LOG2:0] exp_level;
      logic                exp_full;
   } vec_t;

   vec_t vec[17];

   int n_tests      = 0;
   int n_fail       = 0;
   int cyc          = 0;
   int n_starts     = 0;
   int sym_unstable = 0;
   int dac_busy     = 3;
   int busy_cnt     = 0;
   bit dac_hold     = 1'b0;
   bit prev_start   = 1'b0;
   logic [SYM_W-1:0] cap_sym = '0;
   logic [SYM_W-1:0] got[$];
   int               got_cyc[$];

   always @(posedge HCLK) cyc++;

   // DAC writer: drops ready on start, stays busy dac_busy cycles, returns ready once start is low.
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         bus_if.dac_ready = 1'b1;
         busy_cnt         = 0;
         prev_start       = 1'b0;
      end else begin
         if (bus_if.dac_start && !prev_start) begin
            n_starts++;
            got.push_back(bus_if.symbol);
            got_cyc.push_back(cyc);
            cap_sym = bus_if.symbol;
         end
         prev_start = bus_if.dac_start;
         if (bus_if.dac_ready) begin
            if (bus_if.dac_start && !dac_hold) begin
               bus_if.dac_ready = 1'b0;
               busy_cnt         = dac_busy;
            end
         end else begin
            if (bus_if.symbol != cap_sym) sym_unstable++;
            if (busy_cnt > 1) busy_cnt--;
            else if (!bus_if.dac_start) bus_if.dac_ready = 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic push1(input logic [SYM_W-1:0] d);
      bus_if.push      = 1'b1;
      bus_if.push_data = d;
      step();
      bus_if.push      = 1'b0;
   endtask

   task automatic wait_starts(input int target, input int max_cyc, input string name);
      int k;
      k = 0;
      while (n_starts < target && k < max_cyc) begin
         step();
         k++;
      end
      check(name, n_starts, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      int s0;
      int s1;
      int u0;
      int k;

      bus_if.push         = 1'b0;
      bus_if.push_data    = '0;
      bus_if.enable       = 1'b0;
      bus_if.sym_period   = 16'd8;
      bus_if.clr_underrun = 1'b0;
`ifdef SYMBOL_PACER_IDLE_SYMBOL_EN
      bus_if.idle_symbol  = 6'h15;
`endif

      for (int i = 0; i < 17; i++) begin
         vec[i].din       = SYM_W'(i * 7 + 3);
         vec[i].exp_level = (i < 16) ? (DEPTH_LOG2+1)'(i + 1) : (DEPTH_LOG2+1)'(16);
         vec[i].exp_full  = (i >= 15);
      end

      // reset values
      repeat (3) step();
      check("rst_symbol",    bus_if.symbol,    0);
      check("rst_dac_start", bus_if.dac_start, 0);
      check("rst_underrun",  bus_if.underrun,  0);
      check("rst_level",     bus_if.level,     0);
      check("rst_full",      bus_if.full,      0);
      HRESETn = 1'b1;
      step();

      // three symbols at period 8, then an underrun on the fourth tick
      b = got.size(); s0 = n_starts; dac_busy = 3;
      push1(6'h05); push1(6'h2A); push1(6'h3F);
      check("t1_level_after_push", bus_if.level, 3);
      bus_if.enable = 1'b1;
      wait_starts(s0 + 3, 100, "t1_three_starts");
      check("t1_no_underrun_yet", bus_if.underrun, 0);
      k = 0;
      while (bus_if.underrun !== 1'b1 && k < 40) begin step(); k++; end
      check("t1_underrun_set",   bus_if.underrun, 1);
      check("t1_starts_total",   n_starts - s0, 3);
      check("t1_level_drained",  bus_if.level, 0);
      check("t1_sym0", got[b],   6'h05);
      check("t1_sym1", got[b+1], 6'h2A);
      check("t1_sym2", got[b+2], 6'h3F);
      check("t1_spacing01", got_cyc[b+1] - got_cyc[b],   8);
      check("t1_spacing12", got_cyc[b+2] - got_cyc[b+1], 8);
      bus_if.enable = 1'b0;
      repeat (10) step();
      bus_if.clr_underrun = 1'b1; step(); bus_if.clr_underrun = 1'b0; step();
      check("t1_underrun_cleared", bus_if.underrun, 0);

      // fill to 16 with enable low, 17th dropped, then drain in order
      b = got.size(); s0 = n_starts; bus_if.sym_period = 16'd2; dac_busy = 2;
      for (int i = 0; i < 17; i++) begin
         push1(vec[i].din);
         check($sformatf("t2_level_%0d", i), bus_if.level, vec[i].exp_level);
         check($sformatf("t2_full_%0d", i),  bus_if.full,  vec[i].exp_full);
      end
      bus_if.enable = 1'b1;
      wait_starts(s0 + 16, 400, "t2_sixteen_starts");
      bus_if.enable = 1'b0;
      repeat (20) step();
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t2_order_%0d", i), got[b+i], vec[i].din);
      end
      check("t2_no_extra",     n_starts - s0, 16);
      check("t2_level_empty",  bus_if.level, 0);
      check("t2_full_cleared", bus_if.full, 0);

      // period shorter than DAC write: back-to-back issues, pending ticks collapse
      b = got.size(); s0 = n_starts; u0 = sym_unstable; dac_busy = 10;
      push1(6'h11); push1(6'h22); push1(6'h33); push1(6'h0C);
      bus_if.enable = 1'b1;
      wait_starts(s0 + 4, 200, "t3_four_starts");
      bus_if.enable = 1'b0;
      repeat (30) step();
      check("t3_exactly_four",   n_starts - s0, 4);
      check("t3_symbol_stable",  sym_unstable - u0, 0);
      check("t3_sym0", got[b],   6'h11);
      check("t3_sym3", got[b+3], 6'h0C);
      check("t3_b2b_spacing01", got_cyc[b+1] - got_cyc[b],   13);
      check("t3_b2b_spacing23", got_cyc[b+3] - got_cyc[b+2], 13);

      // push and pop on the same edge at level 5
      b = got.size(); s0 = n_starts; bus_if.sym_period = 16'd8; dac_busy = 3;
      push1(6'h01); push1(6'h02); push1(6'h04); push1(6'h08); push1(6'h10);
      check("t4_level5", bus_if.level, 5);
      bus_if.enable = 1'b1;
      repeat (8) step();
      bus_if.push = 1'b1; bus_if.push_data = 6'h2B;
      step();
      bus_if.push = 1'b0;
      @(negedge HCLK);
      check("t4_issue_aligned",  bus_if.dac_start, 1);
      check("t4_level_held",     bus_if.level, 5);
      check("t4_symbol_head",    bus_if.symbol, 6'h01);
      wait_starts(s0 + 6, 150, "t4_six_starts");
      bus_if.enable = 1'b0;
      repeat (15) step();
      check("t4_order4", got[b+4], 6'h10);
      check("t4_order5", got[b+5], 6'h2B);

      // reset while dac_start is held in START
      s0 = n_starts; dac_hold = 1'b1; bus_if.sym_period = 16'd4;
      push1(6'h3A); push1(6'h07);
      bus_if.enable = 1'b1;
      k = 0;
      while (bus_if.dac_start !== 1'b1 && k < 30) begin @(negedge HCLK); k++; end
      check("t5_start_seen", bus_if.dac_start, 1);
      #2 HRESETn = 1'b0;
      #1;
      check("t5_rst_dac_start", bus_if.dac_start, 0);
      check("t5_rst_level",     bus_if.level, 0);
      check("t5_rst_symbol",    bus_if.symbol, 0);
      bus_if.enable = 1'b0;
      dac_hold = 1'b0;
      step(); step();
      HRESETn = 1'b1;
      s1 = n_starts;
      repeat (20) step();
      check("t5_no_spurious",   n_starts - s1, 0);
      check("t5_one_before",    s1 - s0, 1);
      check("t5_start_low",     bus_if.dac_start, 0);

      // clr_underrun versus tick timing on an empty FIFO, period 4
      b = got.size(); s0 = n_starts; dac_busy = 1;
      bus_if.clr_underrun = 1'b1; step(); bus_if.clr_underrun = 1'b0; step();
      check("t6_pre_clear", bus_if.underrun, 0);
      bus_if.enable = 1'b1;
      repeat (4) step();
      @(negedge HCLK);
      check("t6_underrun_tick", bus_if.underrun, 1);
      step();
      bus_if.clr_underrun = 1'b1; step(); bus_if.clr_underrun = 1'b0;
      @(negedge HCLK);
      check("t6_clr_no_tick", bus_if.underrun, 0);
      step();
      bus_if.clr_underrun = 1'b1; step(); bus_if.clr_underrun = 1'b0;
      @(negedge HCLK);
      check("t6_set_wins", bus_if.underrun, 1);
      bus_if.enable = 1'b0;
      repeat (8) step();
`ifdef SYMBOL_PACER_IDLE_SYMBOL_EN
      check("t6_idle_starts",  n_starts - s0, 2);
      check("t6_idle_sym",     got[b], 6'h15);
      check("t6_idle_spacing", got_cyc[b+1] - got_cyc[b], 4);
      check("t6_symbol_idle",  bus_if.symbol, 6'h15);
`else
      check("t6_no_dac_write", n_starts - s0, 0);
      check("t6_symbol_held",  bus_if.symbol, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
